// File: rtl/io_initiator_if.sv
// Link bundle for the io_initiator: local command port, packed request channel,
// packed response channel, local completion port and status outputs.
interface io_initiator_if #(
    parameter int SIGNAL_WIDTH = 4,
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int DW           = 32
);
    // local command
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    // packed request to responder
    logic                  req_valid;
    logic [DW-1:0]         req_data;
    logic                  req_ready;
    // packed response from responder
    logic                  rsp_valid;
    logic [DW-1:0]         rsp_data;
    logic                  rsp_ready;
    // local completion
    logic                  cpl_valid;
    logic                  cpl_ready;
    logic                  cpl_write;
    logic [ID_WIDTH-1:0]   cpl_id;
    logic [ADDR_WIDTH-1:0] cpl_addr;
    logic [DATA_WIDTH-1:0] cpl_data;
    logic                  cpl_error;
    // status
    logic [ID_WIDTH:0]     outstanding;
    logic                  timeout_err;

    // initiator view
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output req_valid, req_data,
        input  req_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        output cpl_valid, cpl_write, cpl_id, cpl_addr, cpl_data, cpl_error,
        input  cpl_ready,
        output outstanding, timeout_err
    );

    // host / responder view
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  req_valid, req_data,
        output req_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        input  cpl_valid, cpl_write, cpl_id, cpl_addr, cpl_data, cpl_error,
        output cpl_ready,
        input  outstanding, timeout_err
    );
endinterface

// File: rtl/io_initiator.sv
// io_initiator: requester end of the packed {signal,id,addr,data} link.
// Tags local commands with an ID, issues packed requests, tracks in-flight
// IDs in a per-ID table and turns returning responses into local completions.
// DW must equal SIGNAL_WIDTH+ID_WIDTH+ADDR_WIDTH+DATA_WIDTH.
module io_initiator #(
    parameter int DW           = 32,
    parameter int SIGNAL_WIDTH = 4,
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_OUTST    = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    io_initiator_if.master bus
);
    localparam int DEPTH = 2 ** ID_WIDTH;
    localparam int CW    = $clog2(TIMEOUT + 1);
    localparam logic [ID_WIDTH:0] MAX_C = (ID_WIDTH + 1)'(MAX_OUTST);
    localparam logic [CW-1:0]     TO_C  = CW'(TIMEOUT);
    localparam logic [ID_WIDTH-1:0] ID_ONE = ID_WIDTH'(1);
    localparam logic [ID_WIDTH:0]   CNT_ONE = (ID_WIDTH + 1)'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } req_state_e;

    // request channel registers
    req_state_e            state_q;
    logic                  req_valid_q;
    logic [DW-1:0]         req_data_q;
    // in-flight table, one entry per ID
    logic [DEPTH-1:0]      tbl_v_q;
    logic [DEPTH-1:0]      tbl_w_q;
    logic [ADDR_WIDTH-1:0] tbl_a_q [DEPTH];
    logic [ID_WIDTH-1:0]   next_id_q;
    logic [ID_WIDTH:0]     outst_q, outst_d;
    // completion register
    logic                  cpl_valid_q;
    logic                  cpl_write_q;
    logic [ID_WIDTH-1:0]   cpl_id_q;
    logic [ADDR_WIDTH-1:0] cpl_addr_q;
    logic [DATA_WIDTH-1:0] cpl_data_q;
    logic                  cpl_error_q;
    // watchdog
    logic [CW-1:0]         wd_cnt_q, wd_cnt_d;
    logic                  timeout_q, timeout_d;

    // response field decode
    logic                  rsp_wr_s;
    logic [ID_WIDTH-1:0]   rsp_id_s;
    logic [ADDR_WIDTH-1:0] rsp_addr_s;
    logic [DATA_WIDTH-1:0] rsp_dat_s;
    logic                  unused_sig_s;

    logic                  rsp_ready_s, rsp_fire_s, rsp_hit_s, free_s;
    logic                  next_busy_s, cmd_ready_s, cmd_fire_s;
    logic [ID_WIDTH:0]     outst_pf_s;
    logic [DW-1:0]         req_word_s;

    assign rsp_wr_s     = bus.rsp_data[DW-SIGNAL_WIDTH];
    assign rsp_id_s     = bus.rsp_data[DATA_WIDTH+ADDR_WIDTH +: ID_WIDTH];
    assign rsp_addr_s   = bus.rsp_data[DATA_WIDTH +: ADDR_WIDTH];
    assign rsp_dat_s    = bus.rsp_data[DATA_WIDTH-1:0];
    // upper signal bits carry no meaning on the response side
    assign unused_sig_s = ^bus.rsp_data[DW-1:DW-SIGNAL_WIDTH+1];

    // Handshake decisions; a freed entry is visible to cmd_ready in the same cycle
    always_comb begin
        rsp_ready_s = ~cpl_valid_q | bus.cpl_ready;
        rsp_fire_s  = bus.rsp_valid & rsp_ready_s;
        rsp_hit_s   = tbl_v_q[rsp_id_s] & (tbl_w_q[rsp_id_s] == rsp_wr_s) &
                      (tbl_a_q[rsp_id_s] == rsp_addr_s);
        free_s      = rsp_fire_s & rsp_hit_s;
        next_busy_s = tbl_v_q[next_id_q] & ~(free_s & (rsp_id_s == next_id_q));
        if (free_s) begin
            outst_pf_s = outst_q - CNT_ONE;
        end else begin
            outst_pf_s = outst_q;
        end
        cmd_ready_s = ((state_q == ST_IDLE) | bus.req_ready) & (outst_pf_s < MAX_C) & ~next_busy_s;
        cmd_fire_s  = bus.cmd_valid & cmd_ready_s;
        req_word_s  = {{(SIGNAL_WIDTH-1){1'b0}}, bus.cmd_write, next_id_q, bus.cmd_addr,
                       bus.cmd_write ? bus.cmd_wdata : {DATA_WIDTH{1'b0}}};
    end

    // Outstanding count: +1 on allocate, -1 on hit
    always_comb begin
        case ({cmd_fire_s, free_s})
            2'b10:   outst_d = outst_q + CNT_ONE;
            2'b01:   outst_d = outst_q - CNT_ONE;
            default: outst_d = outst_q;
        endcase
    end

    // Watchdog next state: idle or progress clears, otherwise count and saturate
    always_comb begin
        if (rsp_fire_s || (outst_q == {(ID_WIDTH+1){1'b0}})) begin
            wd_cnt_d = {CW{1'b0}};
        end else if (wd_cnt_q != TO_C) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
        timeout_d = timeout_q | (wd_cnt_d == TO_C);
    end

    // Request channel FSM: payload held stable while PEND until req_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_valid_q <= 1'b0;
            req_data_q  <= {DW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire_s) begin
                        req_data_q  <= req_word_s;
                        req_valid_q <= 1'b1;
                        state_q     <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (cmd_fire_s) begin
                        req_data_q <= req_word_s;
                    end else if (bus.req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    req_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // In-flight table, ID allocator and outstanding counter; allocate overrides free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_v_q   <= {DEPTH{1'b0}};
            tbl_w_q   <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                tbl_a_q[i] <= {ADDR_WIDTH{1'b0}};
            end
            next_id_q <= {ID_WIDTH{1'b0}};
            outst_q   <= {(ID_WIDTH+1){1'b0}};
        end else begin
            if (free_s) begin
                tbl_v_q[rsp_id_s] <= 1'b0;
            end
            if (cmd_fire_s) begin
                tbl_v_q[next_id_q] <= 1'b1;
                tbl_w_q[next_id_q] <= bus.cmd_write;
                tbl_a_q[next_id_q] <= bus.cmd_addr;
                next_id_q          <= next_id_q + ID_ONE;
            end
            outst_q <= outst_d;
        end
    end

    // Completion register: loaded on response accept, cleared when consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpl_valid_q <= 1'b0;
            cpl_write_q <= 1'b0;
            cpl_id_q    <= {ID_WIDTH{1'b0}};
            cpl_addr_q  <= {ADDR_WIDTH{1'b0}};
            cpl_data_q  <= {DATA_WIDTH{1'b0}};
            cpl_error_q <= 1'b0;
        end else if (rsp_fire_s) begin
            cpl_valid_q <= 1'b1;
            cpl_write_q <= rsp_wr_s;
            cpl_id_q    <= rsp_id_s;
            cpl_addr_q  <= rsp_addr_s;
            cpl_data_q  <= rsp_dat_s;
            cpl_error_q <= ~rsp_hit_s;
        end else if (bus.cpl_ready) begin
            cpl_valid_q <= 1'b0;
        end
    end

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q  <= {CW{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_s;
    assign bus.req_valid   = req_valid_q;
    assign bus.req_data    = req_data_q;
    assign bus.rsp_ready   = rsp_ready_s;
    assign bus.cpl_valid   = cpl_valid_q;
    assign bus.cpl_write   = cpl_write_q;
    assign bus.cpl_id      = cpl_id_q;
    assign bus.cpl_addr    = cpl_addr_q;
    assign bus.cpl_data    = cpl_data_q;
    assign bus.cpl_error   = cpl_error_q;
    assign bus.outstanding = outst_q;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_io_initiator.sv
// Bench for io_initiator: directed link scenarios plus a randomized phase, all
// checked cycle by cycle against a transaction-level model of the initiator
// and a behavioural register-file responder.
module tb_io_initiator;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    io_initiator_if #(.SIGNAL_WIDTH(4), .ID_WIDTH(4), .ADDR_WIDTH(8), .DATA_WIDTH(16), .DW(32)) bus();

    io_initiator #(.DW(32), .SIGNAL_WIDTH(4), .ID_WIDTH(4), .ADDR_WIDTH(8), .DATA_WIDTH(16),
                   .MAX_OUTST(4), .TIMEOUT(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: in-flight set keyed by ID, request register, completion register
    bit   [15:0] m_busy;
    bit   [15:0] m_w;
    logic [7:0]  m_a [16];
    logic [3:0]  m_next;
    int          m_cnt;
    bit          m_pend;
    logic [31:0] m_req;
    bit          m_cpl_v;
    logic [31:0] m_cpl;
    bit          m_cpl_err;
    // responder
    logic [31:0] issued_q [$];
    logic [15:0] mem [256];
    // per-cycle observations
    bit g_cfire, g_rfire, g_cmd_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] respond(input logic [31:0] w);
        if (w[28]) begin
            mem[w[23:16]] = w[15:0];
            return w;
        end
        return {w[31:16], mem[w[23:16]]};
    endfunction

    task automatic model_reset();
        m_busy = '0; m_w = '0; m_next = 4'd0; m_cnt = 0; m_pend = 1'b0; m_cpl_v = 1'b0;
    endtask

    // Asynchronous reset, checked before any clock edge; returns at posedge+1
    task automatic do_reset();
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h00; bus.cmd_wdata = 16'h0000;
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = 32'h0; bus.cpl_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 64'(bus.req_valid), 64'd0);
        chk("rst_req_data", 64'(bus.req_data), 64'd0);
        chk("rst_cpl_valid", 64'(bus.cpl_valid), 64'd0);
        chk("rst_cpl_error", 64'(bus.cpl_error), 64'd0);
        chk("rst_cpl_payload", 64'({bus.cpl_write, bus.cpl_id, bus.cpl_addr, bus.cpl_data}), 64'd0);
        chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
        chk("rst_timeout", 64'(bus.timeout_err), 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: drive inputs, check every output against the model, advance model
    task automatic cycle(input bit cv, input bit cw, input logic [7:0] ca, input logic [15:0] cd,
                         input bit rr, input bit rv, input logic [31:0] rd, input bit cr);
        bit rsp_rdy_e, hit, busy_pf, cmd_rdy_e;
        int cnt_pf;
        logic [3:0] rid;
        bus.cmd_valid = cv; bus.cmd_write = cw; bus.cmd_addr = ca; bus.cmd_wdata = cd;
        bus.req_ready = rr; bus.rsp_valid = rv; bus.rsp_data = rd; bus.cpl_ready = cr;
        #1;
        rid       = rd[27:24];
        rsp_rdy_e = !m_cpl_v || cr;
        g_rfire   = rv && rsp_rdy_e;
        hit       = g_rfire && m_busy[rid] && (m_w[rid] == rd[28]) && (m_a[rid] == rd[23:16]);
        cnt_pf    = m_cnt - (hit ? 1 : 0);
        busy_pf   = m_busy[m_next] && !(hit && (rid == m_next));
        cmd_rdy_e = (!m_pend || rr) && (cnt_pf < 4) && !busy_pf;
        g_cfire   = cv && cmd_rdy_e;
        g_cmd_rdy = bus.cmd_ready;
        chk("cmd_ready", 64'(bus.cmd_ready), 64'(cmd_rdy_e));
        chk("rsp_ready", 64'(bus.rsp_ready), 64'(rsp_rdy_e));
        chk("req_valid", 64'(bus.req_valid), 64'(m_pend));
        if (m_pend) chk("req_data", 64'(bus.req_data), 64'(m_req));
        chk("cpl_valid", 64'(bus.cpl_valid), 64'(m_cpl_v));
        if (m_cpl_v) begin
            chk("cpl_fields", 64'({bus.cpl_write, bus.cpl_id, bus.cpl_addr, bus.cpl_data}),
                64'({m_cpl[28], m_cpl[27:0]}));
            chk("cpl_error", 64'(bus.cpl_error), 64'(m_cpl_err));
        end
        chk("outstanding", 64'(bus.outstanding), 64'(m_cnt));
        // model update for the coming edge
        if (m_pend && rr) issued_q.push_back(m_req);
        if (hit) begin m_busy[rid] = 1'b0; m_cnt--; end
        if (g_cfire) begin
            m_req = {3'b000, cw, m_next, ca, cw ? cd : 16'h0000};
            m_busy[m_next] = 1'b1; m_w[m_next] = cw; m_a[m_next] = ca;
            m_next = m_next + 4'd1; m_cnt++; m_pend = 1'b1;
        end else if (rr) begin
            m_pend = 1'b0;
        end
        if (g_rfire) begin
            m_cpl_v = 1'b1; m_cpl = rd; m_cpl_err = !hit;
        end else if (cr) begin
            m_cpl_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Let the responder return everything in flight; bounded
    task automatic drain(input bit v0, input logic [31:0] w0);
        bit v = v0;
        logic [31:0] w = w0;
        int k = 0;
        while (k < 300 && (issued_q.size() != 0 || m_cnt != 0 || m_pend || v)) begin
            if (!v && issued_q.size() > 0) begin w = respond(issued_q.pop_front()); v = 1'b1; end
            cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, v, w, 1'b1);
            if (g_rfire) v = 1'b0;
            k++;
        end
        chk("drain_budget", 64'(k < 300), 64'd1);
        chk("drain_outstanding", 64'(bus.outstanding), 64'd0);
    endtask

    initial begin
        bit cv, cw, rv, rr, cr;
        logic [7:0]  ca;
        logic [15:0] cd;
        logic [31:0] rcur;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst_n = 1'b1;
        #2;
        do_reset();

        // T1 write, T2 read back through the responder
        cycle(1'b1, 1'b1, 8'h12, 16'hBEEF, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t1_req_data", 64'(bus.req_data), 64'h1012BEEF);
        chk("t1_req_valid", 64'(bus.req_valid), 64'd1);
        chk("t1_outstanding", 64'(bus.outstanding), 64'd1);
        cycle(1'b1, 1'b0, 8'h12, 16'h5555, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t2_req_data", 64'(bus.req_data), 64'h01120000);
        cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, respond(issued_q.pop_front()), 1'b1);
        chk("t2_wr_cpl_err", 64'(bus.cpl_error), 64'd0);
        cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, respond(issued_q.pop_front()), 1'b1);
        chk("t2_cpl_valid", 64'(bus.cpl_valid), 64'd1);
        chk("t2_cpl_id", 64'(bus.cpl_id), 64'd1);
        chk("t2_cpl_data", 64'(bus.cpl_data), 64'hBEEF);
        chk("t2_cpl_error", 64'(bus.cpl_error), 64'd0);
        chk("t2_outstanding", 64'(bus.outstanding), 64'd0);

        // T3 capacity: responses withheld, fifth command stalls until a hit frees one
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b1, 8'(8'h20 + i), 16'(16'h0100 + i), 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t3_outstanding_full", 64'(bus.outstanding), 64'd4);
        cycle(1'b1, 1'b1, 8'h30, 16'h0A0A, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t3_stall", 64'(g_cmd_rdy), 64'd0);
        cycle(1'b1, 1'b1, 8'h30, 16'h0A0A, 1'b1, 1'b1, respond(issued_q.pop_front()), 1'b1);
        chk("t3_release", 64'(g_cmd_rdy), 64'd1);
        drain(1'b0, 32'h0);

        // T4 response for an unallocated ID
        cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 32'h07330000, 1'b1);
        chk("t4_cpl_error", 64'(bus.cpl_error), 64'd1);
        chk("t4_cpl_id", 64'(bus.cpl_id), 64'd7);
        chk("t4_outstanding", 64'(bus.outstanding), 64'd0);
        cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b1);

        // T5 ID wrap: 17 write/complete pairs after reset
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 1'b1, 8'(i), 16'(i * 3 + 1), 1'b1, 1'b0, 32'h0, 1'b1);
            chk("t5_no_stall", 64'(g_cmd_rdy), 64'd1);
            cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b1);
            cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, respond(issued_q.pop_front()), 1'b1);
            chk("t5_cpl_id", 64'(bus.cpl_id), 64'(i % 16));
            chk("t5_cpl_error", 64'(bus.cpl_error), 64'd0);
        end

        // Randomized traffic against the model, including stray responses
        cv = 1'b0; rv = 1'b0; rcur = 32'h0; g_cfire = 1'b0; g_rfire = 1'b0;
        cw = 1'b0; ca = 8'h00; cd = 16'h0000;
        for (int k = 0; k < 600; k++) begin
            if (!cv || g_cfire) begin
                cv = ($urandom_range(0, 9) < 6);
                cw = 1'($urandom_range(0, 1));
                ca = 8'($urandom_range(0, 15));
                cd = 16'($urandom);
            end
            if (rv && g_rfire) rv = 1'b0;
            if (!rv) begin
                if (issued_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    rcur = respond(issued_q.pop_front()); rv = 1'b1;
                end else if ($urandom_range(0, 19) == 0) begin
                    rcur = {3'b000, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                            8'($urandom_range(0, 15)), 16'($urandom)};
                    rv = 1'b1;
                end
            end
            rr = ($urandom_range(0, 3) != 0);
            cr = ($urandom_range(0, 3) != 0);
            cycle(cv, cw, ca, cd, rr, rv, rcur, cr);
        end
        drain(rv && !g_rfire, rcur);
        chk("rand_no_timeout", 64'(bus.timeout_err), 64'd0);

        // T6 watchdog, then reset mid-request and a late response
        do_reset();
        issued_q.delete();
        cycle(1'b1, 1'b0, 8'h40, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 59; i++) cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t6_timeout_early", 64'(bus.timeout_err), 64'd0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t6_timeout_set", 64'(bus.timeout_err), 64'd1);
        cycle(1'b1, 1'b1, 8'h41, 16'h1234, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t6_pend", 64'(bus.req_valid), 64'd1);
        do_reset();
        cycle(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, respond(issued_q.pop_front()), 1'b1);
        chk("t6_late_error", 64'(bus.cpl_error), 64'd1);
        chk("t6_late_outstanding", 64'(bus.outstanding), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
